gray_to_binary_seq: RTL and testbench
=====================================

# gray_to_binary_seq

Sequential Gray-to-binary decoder that inverts the lab's binary-to-Gray converter. It latches a WIDTH-bit Gray word on a start/ready handshake and resolves it MSB-first, one bit per clock. It then presents the binary result, a done pulse and a 7-segment hex digit of the result's low nibble. It sits after the switch/Gray input path and drives the board's seven-segment display.

## Interface
- WIDTH, 4, Gray/binary word width; legal range 2..16
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while ready=1
- gray_in  in  WIDTH  Gray-coded word, latched on accepted start
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when binary_out is updated
- binary_out  out  WIDTH  registered decoded value; holds until next done
- seg_out  out  7  active-low segments {g,f,e,d,c,b,a}, hex digit of binary_out[3:0] (zero-extended if WIDTH<4)

## Operation
- States: IDLE, DECODE, DONE.
- IDLE: ready=1. On start=1:
  - latch gray_in into gray_q
  - set bin_q[WIDTH-1]=gray_in[WIDTH-1] and idx=WIDTH-2
  - go to DECODE
  - start=0 keeps the block in IDLE.
- DECODE: each cycle, bin_q[idx]=bin_q[idx+1]^gray_q[idx].
  - If idx==0, load binary_out<=computed word and go to DONE; otherwise idx<=idx-1.
  - idx is $clog2(WIDTH) bits wide and counts down with no wrap.
- DONE: done=1 for exactly this cycle, then unconditionally to IDLE.
- Handshake:
  - start is ignored while ready=0 (DECODE, DONE); no queuing.
  - gray_in changes after acceptance have no effect.
- seg_out is combinational from binary_out (decoder sub-module), so it changes in the same cycle done rises.
  - Digit patterns: 0=1000000, 1=1111001, …, A=0001000, E=0000110, F=0001110.
- Reset (any time, including mid-DECODE):
  - state=IDLE, binary_out=0, done=0, gray_q/bin_q/idx=0
  - ready=1, seg_out=7'b1000000
  - An interrupted decode produces no done and no output update.

## Timing
- start accepted at rising edge E0 → done high during the cycle after edge E0+(WIDTH-1).
  - WIDTH=4: done high 3 cycles after acceptance.
- binary_out and seg_out valid from the same edge that raises done, stable until the next done.
- ready falls at E0, returns at edge E0+WIDTH.
  - Earliest next acceptance is at E0+WIDTH.
  - Throughput: one word per WIDTH cycles with start held high.
- Async reset takes effect immediately, without waiting for a clock edge.
  - First acceptance is possible at the first rising edge after rst deasserts.

## Structure
- Package gray_pkg:
  - state typedef enum logic [1:0] {IDLE, DECODE, DONE}
  - 16-entry active-low segment constant table SEG_HEX
- Sub-module hex_to_7seg: combinational 4-bit → 7-bit lookup using SEG_HEX; instantiated once on binary_out[3:0].
- Top level holds the FSM, gray_q, bin_q, idx and the binary_out register.

## Test plan
- Reset: rst=1 mid-simulation → binary_out=0, done=0, ready=1, seg_out=1000000 without a clock edge.
- gray_in=4'b1001, start pulse → done exactly 3 cycles later, binary_out=4'b1110, seg_out=0000110.
- gray_in=4'b1111 → binary_out=4'b1010, seg_out=0001000. Then gray_in=4'b0000 → binary_out=0, seg_out=1000000.
- Busy rejection: accept 4'b0011, then pulse start with 4'b1000 one cycle later → ready=0, only one done, binary_out=4'b0010.
- Exhaustive round-trip: all 16 Gray codes back-to-back with start held high, each compared to the prefix-XOR model → 16 done pulses, one every 4 cycles, all match.
- Reset mid-DECODE: rst pulse on the second DECODE cycle after accepting 4'b1100 → no done, binary_out=0. A fresh 4'b1100 then yields 4'b1000.

Source files
------------

// File: rtl/gray_to_binary_seq_pkg.sv
// Shared types and constants for the sequential Gray-to-binary decoder
// and its seven-segment display stage.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SEG_W = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}, indexed by hex digit.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/gray_to_binary_seq_if.sv
// Request/result bundle between the switch/Gray input path and the decoder.
// The master side issues start/gray_in; the slave side returns the result.
interface gray_to_binary_seq_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] gray_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] binary_out;
  logic [6:0]       seg_out;

  modport master (
    output start, gray_in,
    input  ready, done, binary_out, seg_out
  );

  modport slave (
    input  start, gray_in,
    output ready, done, binary_out, seg_out
  );

endinterface

// File: rtl/gray_to_binary_seq_hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment lookup.
module hex_to_7seg
  import gray_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/gray_to_binary_seq.sv
// Sequential Gray-to-binary decoder: latches a Gray word on start/ready,
// resolves it MSB-first one bit per clock, then publishes result and done.
module gray_to_binary_seq
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_to_binary_seq_if.slave   bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] bout_q, bout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WIDTH-1:0] bin_shift;
  logic [WIDTH-1:0] decode_word;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_bit = (idx_q == '0);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DECODE;
      DECODE:  if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == IDLE);
    bus.done  = (state_q == DONE);
  end

  // ----------------------------------------------------------- datapath
  // Bit idx resolves as the XOR of the already-resolved bit above it and
  // the Gray bit at idx; the shifted copy supplies bin_q[idx+1].
  always_comb begin
    bin_shift   = bin_q >> 1;
    decode_word = bin_q;
    decode_word[idx_q] = bin_shift[idx_q] ^ gray_q[idx_q];
  end

  always_comb begin
    gray_d = gray_q;
    bin_d  = bin_q;
    bout_d = bout_q;
    idx_d  = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gray_d             = bus.gray_in;
          bin_d              = '0;
          bin_d[WIDTH-1]     = bus.gray_in[WIDTH-1];
          idx_d              = IDX_W'(WIDTH - 2);
        end
      end
      DECODE: begin
        bin_d = decode_word;
        if (last_bit) bout_d = decode_word;
        else          idx_d  = idx_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
      bin_q  <= '0;
      bout_q <= '0;
      idx_q  <= '0;
    end else begin
      gray_q <= gray_d;
      bin_q  <= bin_d;
      bout_q <= bout_d;
      idx_q  <= idx_d;
    end
  end

  // ------------------------------------------------------------ outputs
  logic [3:0] nibble;

  assign nibble         = 4'(bout_q);
  assign bus.binary_out = bout_q;

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nibble),
    .seg_o    (bus.seg_out)
  );

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Self-checking bench for gray_to_binary_seq: a cycle-level countdown model
// of the request/result behaviour plus directed literal checks.
module tb_gray_to_binary_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  gray_to_binary_seq_if #(.WIDTH(W)) bus ();

  gray_to_binary_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value of a Gray word: bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Model: m_left counts the cycles a request still occupies the block;
  // W at acceptance, 1 while the done pulse is up, 0 when ready.
  int           m_left = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_bin  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_pend <= '0;
      m_bin  <= '0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_pend <= g2b(bus.gray_in);
        m_left <= W;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_bin <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("ready",      32'(bus.ready),      32'(m_left == 0));
    check("done",       32'(bus.done),       32'(m_left == 1));
    check("binary_out", 32'(bus.binary_out), 32'(m_bin));
    check("seg_out",    32'(bus.seg_out),    32'(seg_ref(m_bin)));
    if (bus.done) done_cnt++;
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  // Issue one request from a negedge; ends on the negedge that shows done.
  task automatic run_word(input logic [W-1:0] g, input logic [W-1:0] exp_b,
                          input logic [6:0] exp_seg, input string tag);
    int n = 0;
    wait_ready();
    bus.start   = 1'b1;
    bus.gray_in = g;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.gray_in = ~g;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_bin"},     32'(bus.binary_out), 32'(exp_b));
    check({tag, "_seg"},     32'(bus.seg_out),    32'(exp_seg));
  endtask

  initial begin
    int d0;
    bus.start   = 1'b0;
    bus.gray_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    run_word(4'b1001, 4'b1110, 7'b0000110, "g1001");
    run_word(4'b1111, 4'b1010, 7'b0001000, "g1111");
    run_word(4'b0000, 4'b0000, 7'b1000000, "g0000");

    // Busy rejection: second start one cycle after acceptance is dropped.
    wait_ready();
    d0 = done_cnt;
    bus.start = 1'b1;  bus.gray_in = 4'b0011;
    @(negedge clk);
    bus.start = 1'b1;  bus.gray_in = 4'b1000;
    check("busy_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_bin", 32'(bus.binary_out), 32'(4'b0010));

    // Reset on the second DECODE cycle: immediate, and no done follows.
    wait_ready();
    d0 = done_cnt;
    bus.start = 1'b1;  bus.gray_in = 4'b1100;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_bin",   32'(bus.binary_out), 32'd0);
    check("rst_done",  32'(bus.done),       32'd0);
    check("rst_ready", 32'(bus.ready),      32'd1);
    check("rst_seg",   32'(bus.seg_out),    32'(7'b1000000));
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_word(4'b1100, 4'b1000, 7'b0000000, "g1100");

    // All Gray codes back-to-back with start held high.
    wait_ready();
    d0 = done_cnt;
    bus.start = 1'b1;
    for (int g = 0; g < 16; g++) begin
      wait_ready();
      bus.gray_in = 4'(g);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("sweep_done_count", 32'(done_cnt - d0), 32'd16);

    // Random traffic, including starts while busy and one async reset.
    for (int c = 0; c < 400; c++) begin
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.gray_in = W'($urandom);
      if (c == 200) begin
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
